// File: rtl/sc_imem_loader_if.sv
// -----------------------------------------------------------------------------
// sc_imem_loader_if
//
// Boot byte stream between a byte source (for example a UART receiver) and the
// instruction-memory loader. A byte moves on a rising clock edge when
// rx_valid and rx_ready are both high.
//
// Signals:
//   rx_data   [7:0]  boot byte, driven by the source
//   rx_valid         rx_data holds a byte, driven by the source
//   rx_ready         loader accepts a byte this cycle, driven by the loader
//
// Modports:
//   master  byte source (drives rx_data/rx_valid, reads rx_ready)
//   slave   loader      (reads rx_data/rx_valid, drives rx_ready)
// -----------------------------------------------------------------------------
interface sc_imem_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/sc_imem_loader.sv
// -----------------------------------------------------------------------------
// sc_imem_loader
//
// Instruction memory that sits directly in front of the single-cycle CPU.
// After resetn is released it boot-loads its RAM from a byte stream and
// keeps the CPU in reset until the load completes. Once running, it returns
// the instruction addressed by the CPU program counter combinationally.
//
// Stream format (all fields little-endian):
//   2 bytes  word count len (0 .. DEPTH)
//   4*len    instruction words, byte 0 = bits 7:0
//   1 byte   XOR of all previous bytes (only when SC_IMEM_CSUM_EN is defined)
//
// Parameters:
//   ADDR_W      word-address width; RAM depth DEPTH = 2**ADDR_W 32-bit words
//
// Ports:
//   clock       system clock, rising edge
//   resetn      asynchronous active-low reset; the only way to restart a load
//   rx          boot byte stream (slave side of sc_imem_loader_if)
//   pc          CPU program counter; bits 1:0 and bits above ADDR_W+1 ignored
//   inst        instruction at pc, forced to 0 until the load has completed
//   cpu_resetn  active-low CPU reset, registered, rises one cycle after RUN
//   load_done   load completed successfully
//   err         load failed (length overflow or bad checksum), sticky
//
// Optional feature (compile-time macro SC_IMEM_CSUM_EN):
//   When defined, a trailing checksum byte is required after the data and
//   must equal the XOR of every header and data byte, otherwise the load
//   ends in ERROR. When undefined, there is no checksum byte and err is set
//   only by a length larger than DEPTH.
// -----------------------------------------------------------------------------
module sc_imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic                   clock,
    input  logic                   resetn,
    sc_imem_loader_if.slave        rx,
    input  logic [31:0]            pc,
    output logic [31:0]            inst,
    output logic                   cpu_resetn,
    output logic                   load_done,
    output logic                   err
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [16:0]     DEPTH_LEN = 17'(DEPTH);
    localparam logic [ADDR_W:0] WORD_INC  = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        DONE_CHK,
`ifdef SC_IMEM_CSUM_EN
        CSUM,
`endif
        RUN,
        ERROR
    } state_t;

    state_t              state;
    logic [1:0]          byte_cnt;
    // One bit wider than a RAM address so that it can hold len == DEPTH.
    logic [ADDR_W:0]     word_cnt;
    logic [15:0]         len;
    // Bytes 0..2 of the word being assembled; byte 3 comes straight from rx.
    logic [23:0]         shift;
    logic [31:0]         mem [DEPTH];

    logic                xfer;
    logic [15:0]         hdr_len;
    logic [15:0]         word_cnt_ext;
    logic                words_done;
    logic [31:0]         full_word;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic                pc_unused;

`ifdef SC_IMEM_CSUM_EN
    logic [7:0]          csum;
    logic                csum_seen;
    logic                csum_ok;
`endif

    assign word_cnt_ext = 16'(word_cnt);
    assign words_done   = (word_cnt_ext == len);
    // Full length as it will be once the high header byte is taken.
    assign hdr_len      = {rx.rx_data, len[7:0]};
    assign full_word    = {rx.rx_data, shift};
    assign wr_addr      = word_cnt[ADDR_W-1:0];
    // Word address only: byte offset and bits above the RAM wrap away.
    assign rd_addr      = pc[ADDR_W+1:2];
    assign pc_unused    = ^{pc[31:ADDR_W+2], pc[1:0]};

    // Byte acceptance. Once the last word has been written the block spends
    // one more cycle in DATA before moving on; ready is dropped then so that
    // no stray byte is swallowed after the data phase has ended. The same
    // applies to the cycle after the checksum byte has been captured.
    always_comb begin
        rx.rx_ready = 1'b0;
        case (state)
            LEN_LO,
            LEN_HI:   rx.rx_ready = 1'b1;
            DATA:     rx.rx_ready = !words_done;
`ifdef SC_IMEM_CSUM_EN
            CSUM:     rx.rx_ready = !csum_seen;
`endif
            default:  rx.rx_ready = 1'b0;
        endcase
    end

    assign xfer = rx.rx_valid & rx.rx_ready;

    // Load sequencer. All control outputs are registered here: load_done
    // and err are set on the edge that enters RUN or ERROR, cpu_resetn is
    // set from RUN itself so the CPU leaves reset one cycle after RUN entry.
    // RUN and ERROR are terminal; only resetn leaves them.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= LEN_LO;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            len        <= '0;
            shift      <= '0;
            cpu_resetn <= 1'b0;
            load_done  <= 1'b0;
            err        <= 1'b0;
`ifdef SC_IMEM_CSUM_EN
            csum_seen  <= 1'b0;
            csum_ok    <= 1'b0;
`endif
        end else begin
            case (state)
                LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= rx.rx_data;
                        state    <= LEN_HI;
                    end
                end

                LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= rx.rx_data;
                        if (hdr_len == 16'd0) begin
                            state <= DONE_CHK;
                        end else if ({1'b0, hdr_len} > DEPTH_LEN) begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (words_done) begin
                        state <= DONE_CHK;
                    end else if (xfer) begin
                        if (byte_cnt == 2'd3) begin
                            byte_cnt <= '0;
                            word_cnt <= word_cnt + WORD_INC;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                            shift    <= {rx.rx_data, shift[23:8]};
                        end
                    end
                end

                DONE_CHK: begin
`ifdef SC_IMEM_CSUM_EN
                    state <= CSUM;
`else
                    state     <= RUN;
                    load_done <= 1'b1;
`endif
                end

`ifdef SC_IMEM_CSUM_EN
                // The checksum byte is captured first and judged on the
                // following edge.
                CSUM: begin
                    if (csum_seen) begin
                        if (csum_ok) begin
                            state     <= RUN;
                            load_done <= 1'b1;
                        end else begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end
                    end else if (xfer) begin
                        csum_seen <= 1'b1;
                        csum_ok   <= (rx.rx_data == csum);
                    end
                end
`endif

                RUN: begin
                    cpu_resetn <= 1'b1;
                end

                ERROR: begin
                    cpu_resetn <= 1'b0;
                    load_done  <= 1'b0;
                end

                default: begin
                    state <= LEN_LO;
                end
            endcase
        end
    end

`ifdef SC_IMEM_CSUM_EN
    // Running XOR over every header and data byte actually accepted.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            csum <= '0;
        end else if (xfer && (state == LEN_LO || state == LEN_HI || state == DATA)) begin
            csum <= csum ^ rx.rx_data;
        end
    end
`endif

    // RAM write port. Only whole words are written, on the edge that takes
    // the fourth byte. The RAM has no reset, so a restarted load simply
    // overwrites whatever an earlier load left behind.
    always_ff @(posedge clock) begin
        if (state == DATA && xfer && byte_cnt == 2'd3) begin
            mem[wr_addr] <= full_word;
        end
    end

    // Fetch port. The CPU only sees real instructions once the load is
    // finished; before that (and in ERROR) it reads zeros.
    always_comb begin
        inst = '0;
        if (state == RUN) begin
            inst = mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_sc_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_sc_imem_loader
//
// Self-checking bench for sc_imem_loader (ADDR_W = 6). Boot images are built
// as lists of words, serialised into the little-endian byte stream, and
// delivered with randomized idle gaps. A word-level image of the RAM is kept
// to predict what the CPU fetch port returns after each load. Honours
// SC_IMEM_CSUM_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_sc_imem_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 2 ** ADDR_W;

    // Edges from the last byte of a load to the edge that enters RUN.
`ifdef SC_IMEM_CSUM_EN
    localparam int K_DATA  = 1;
    localparam int K_EMPTY = 1;
`else
    localparam int K_DATA  = 2;
    localparam int K_EMPTY = 1;
`endif

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        cpu_resetn;
    logic        load_done;
    logic        err;

    sc_imem_loader_if rx_if ();

    sc_imem_loader #(
        .ADDR_W     (ADDR_W)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .rx         (rx_if),
        .pc         (pc),
        .inst       (inst),
        .cpu_resetn (cpu_resetn),
        .load_done  (load_done),
        .err        (err)
    );

    always #5 clock = ~clock;

    // Expected RAM image; words never written since power-up are unknown.
    logic [31:0] exp_mem   [DEPTH];
    bit          exp_known [DEPTH];
    logic [31:0] load_words[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present one byte after a number of idle cycles and hold it until it
    // is taken. Returns at the falling edge after the transfer edge.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int waited;
        repeat (gap) begin
            rx_if.rx_valid = 1'b0;
            rx_if.rx_data  = 8'($urandom);
            @(negedge clock);
        end
        rx_if.rx_valid = 1'b1;
        rx_if.rx_data  = b;
        waited = 0;
        while (rx_if.rx_ready !== 1'b1 && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (rx_if.rx_ready !== 1'b1) begin
            checkOutput("ready_timeout", 32'(rx_if.rx_ready), 32'd1);
        end else begin
            @(negedge clock);
        end
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic doReset(input string tag);
        rx_if.rx_valid = 1'b0;
        pc     = 32'h0;
        resetn = 1'b0;
        #1;
        checkOutput({tag, "_rst_ready"}, 32'(rx_if.rx_ready), 32'd1);
        checkOutput({tag, "_rst_cpu"},   32'(cpu_resetn),     32'd0);
        checkOutput({tag, "_rst_done"},  32'(load_done),      32'd0);
        checkOutput({tag, "_rst_err"},   32'(err),            32'd0);
        checkOutput({tag, "_rst_inst"},  inst,                32'd0);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    // Serialise load_words into a boot stream and deliver it. The RAM image
    // is updated as soon as the words have been sent, because words land in
    // the RAM during the data phase whatever the checksum turns out to be.
    task automatic sendLoad(input int gap_min, input int gap_max,
                            input bit force_csum, input logic [7:0] forced_csum);
        logic [7:0] stream[$];
        logic [7:0] x;
        logic [7:0] csum_byte;
        int         n;
        n = load_words.size();
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        foreach (load_words[i]) begin
            for (int j = 0; j < 4; j++) begin
                stream.push_back(8'(load_words[i] >> (8 * j)));
            end
        end
        x = 8'h00;
        foreach (stream[i]) x ^= stream[i];
        csum_byte = force_csum ? forced_csum : x;
        foreach (stream[i]) applyStimulus(stream[i], int'($urandom_range(gap_max, gap_min)));
        foreach (load_words[i]) begin
            exp_mem[i % DEPTH]   = load_words[i];
            exp_known[i % DEPTH] = 1'b1;
        end
`ifdef SC_IMEM_CSUM_EN
        $display("[TB] sending checksum byte %h", csum_byte);
        applyStimulus(csum_byte, 0);
`else
        $display("[TB] stream of %0d words, byte XOR %h", n, csum_byte);
`endif
    endtask

    // RUN is entered k edges after the last byte; cpu_resetn follows one
    // edge later.
    task automatic verifyCompletion(input int k, input string tag);
        for (int i = 0; i < k - 1; i++) begin
            @(negedge clock);
            checkOutput({tag, "_done_early"}, 32'(load_done),  32'd0);
            checkOutput({tag, "_cpu_early"},  32'(cpu_resetn), 32'd0);
            checkOutput({tag, "_inst_early"}, inst,            32'd0);
        end
        @(negedge clock);
        checkOutput({tag, "_done"},    32'(load_done),  32'd1);
        checkOutput({tag, "_cpu_lag"}, 32'(cpu_resetn), 32'd0);
        @(negedge clock);
        checkOutput({tag, "_cpu_rise"}, 32'(cpu_resetn), 32'd1);
        checkOutput({tag, "_err"},      32'(err),        32'd0);
    endtask

    // Fetch every known word through an address with junk in the ignored
    // pc bits, so both the byte offset and the wrap-around are exercised.
    task automatic verifyContents(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            if (exp_known[i]) begin
                pc = ($urandom & ~(32'(DEPTH - 1) << 2)) | (32'(i) << 2);
                #1;
                checkOutput($sformatf("%s_word%0d", tag, i), inst, exp_mem[i]);
            end
        end
        pc = 32'h0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n_words;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        pc             = 32'h0;
        resetn         = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_known[i] = 1'b0;

        // Step 1: reference two-word image, back-to-back bytes.
        $display("[TB] step 1: two-word load");
        doReset("s1");
        load_words = '{32'h2000_0013, 32'h0000_0008};
        applyStimulus(8'h02, 0);
        pc = 32'h0;
        #1;
        checkOutput("s1_inst_loading", inst, 32'd0);
        applyStimulus(8'h00, 0);
        load_words.delete();
        load_words = '{32'h2000_0013, 32'h0000_0008};
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) applyStimulus(8'(load_words[i] >> (8 * j)), 0);
            exp_mem[i]   = load_words[i];
            exp_known[i] = 1'b1;
        end
`ifdef SC_IMEM_CSUM_EN
        applyStimulus(8'h02 ^ 8'h13 ^ 8'h20 ^ 8'h08, 0);
`endif
        verifyCompletion(K_DATA, "s1");
        pc = 32'h4;
        #1;
        checkOutput("s1_inst_pc4", inst, 32'h0000_0008);
        pc = 32'h0;
        #1;
        checkOutput("s1_inst_pc0", inst, 32'h2000_0013);

        // Step 2: same image with rx_valid low every other cycle.
        $display("[TB] step 2: same load with toggling valid");
        doReset("s2");
        load_words = '{32'h2000_0013, 32'h0000_0008};
        sendLoad(1, 1, 1'b0, 8'h00);
        verifyCompletion(K_DATA, "s2");
        verifyContents("s2");

        // Step 3: short random image with random stalls mid-word.
        $display("[TB] step 3: random short load");
        doReset("s3");
        load_words.delete();
        n_words = int'($urandom_range(8, 1));
        for (int i = 0; i < n_words; i++) load_words.push_back($urandom);
        sendLoad(0, 3, 1'b0, 8'h00);
        verifyCompletion(K_DATA, "s3");
        verifyContents("s3");

        // Step 4: length equal to DEPTH fills the RAM exactly.
        $display("[TB] step 4: full-depth load");
        doReset("s4");
        load_words.delete();
        for (int i = 0; i < DEPTH; i++) load_words.push_back($urandom);
        sendLoad(0, 1, 1'b0, 8'h00);
        verifyCompletion(K_DATA, "s4");
        verifyContents("s4");
        pc = 32'h0000_0100 + 32'd20;
        #1;
        checkOutput("s4_wrap", inst, exp_mem[5]);

        // Step 5: empty image, then extra bytes that must be refused.
        $display("[TB] step 5: zero-length load");
        doReset("s5");
        load_words.delete();
        sendLoad(0, 0, 1'b0, 8'h00);
        verifyCompletion(K_EMPTY, "s5");
        rx_if.rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_if.rx_data = 8'($urandom);
            @(negedge clock);
            checkOutput($sformatf("s5_run_ready%0d", i), 32'(rx_if.rx_ready), 32'd0);
        end
        rx_if.rx_valid = 1'b0;
        checkOutput("s5_done_hold", 32'(load_done), 32'd1);
        verifyContents("s5");

        // Step 6: length DEPTH+1 must end in ERROR for good.
        $display("[TB] step 6: oversized length");
        doReset("s6");
        applyStimulus(8'h41, int'($urandom_range(2, 0)));
        applyStimulus(8'h00, 0);
        checkOutput("s6_err",   32'(err),            32'd1);
        checkOutput("s6_ready", 32'(rx_if.rx_ready), 32'd0);
        checkOutput("s6_done",  32'(load_done),      32'd0);
        rx_if.rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rx_if.rx_data = 8'($urandom);
            @(negedge clock);
            if (i % 5 == 4) begin
                checkOutput($sformatf("s6_cpu%0d", i),   32'(cpu_resetn),     32'd0);
                checkOutput($sformatf("s6_ready%0d", i), 32'(rx_if.rx_ready), 32'd0);
                checkOutput($sformatf("s6_err%0d", i),   32'(err),            32'd1);
                checkOutput($sformatf("s6_inst%0d", i),  inst,                32'd0);
            end
        end
        rx_if.rx_valid = 1'b0;

        // Step 7: reset after five data bytes, then a one-word reload.
        $display("[TB] step 7: reset mid-load and reload");
        doReset("s7a");
        load_words = '{$urandom, $urandom};
        applyStimulus(8'h02, 0);
        applyStimulus(8'h00, 0);
        for (int j = 0; j < 4; j++) applyStimulus(8'(load_words[0] >> (8 * j)), 0);
        applyStimulus(8'(load_words[1]), 0);
        exp_mem[0] = load_words[0];
        doReset("s7b");
        load_words = '{32'hDEAD_BEEF};
        sendLoad(0, 2, 1'b0, 8'h00);
        verifyCompletion(K_DATA, "s7");
        pc = 32'h0;
        #1;
        checkOutput("s7_inst_pc0", inst, 32'hDEAD_BEEF);
        pc = 32'h0000_0100;
        #1;
        checkOutput("s7_inst_wrap", inst, 32'hDEAD_BEEF);
        verifyContents("s7");

`ifdef SC_IMEM_CSUM_EN
        // Step 8: checksum accepted, then the same load with a bad checksum.
        $display("[TB] step 8: checksum good and bad");
        doReset("s8a");
        load_words = '{32'h4433_2211};
        sendLoad(0, 1, 1'b0, 8'h00);
        verifyCompletion(1, "s8a");
        verifyContents("s8a");
        doReset("s8b");
        load_words = '{32'h4433_2211};
        sendLoad(0, 1, 1'b1, 8'h00);
        checkOutput("s8b_err_early", 32'(err), 32'd0);
        @(negedge clock);
        checkOutput("s8b_err",  32'(err),       32'd1);
        checkOutput("s8b_done", 32'(load_done), 32'd0);
        @(negedge clock);
        checkOutput("s8b_cpu",  32'(cpu_resetn), 32'd0);
        checkOutput("s8b_inst", inst,            32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
